// File: rtl/dcache_warmup_pkg.sv
// Shared types and default-derived widths for the DCache warmup sequencer.
package dcache_warmup_pkg;

    localparam int unsigned SET_W = $clog2(64);
    localparam int unsigned ROW_W = $clog2(512);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TAG  = 3'd1,
        ST_DATA = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } warmup_state_e;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/warmup_row_counter.sv
// Loadable up-counter with a comparison flag against a caller-supplied terminal value.
module warmup_row_counter #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] last_val,
    output logic [W-1:0] count,
    output logic         at_last_c
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign at_last_c = (count_q == last_val);

endmodule

// File: rtl/dcache_warmup_sequencer.sv
// Streams a warmup image into the DCache tag/data RW0 ports and holds the cache
// in reset until the image is written plus a settle window.
module dcache_warmup_sequencer
    import dcache_warmup_pkg::*;
#(
    parameter int unsigned SETS           = 64,
    parameter int unsigned WAYS           = 4,
    parameter int unsigned TAG_BITS       = 22,
    parameter int unsigned DATA_ROWS      = 512,
    parameter int unsigned DATA_BITS      = 256,
    parameter int unsigned DATA_MASK_BITS = 32,
    parameter int unsigned HOLD_CYCLES    = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        bypass,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_BITS-1:0]        in_data,
    output logic [$clog2(SETS)-1:0]     tag_addr,
    output logic                        tag_en,
    output logic                        tag_wmode,
    output logic [WAYS*TAG_BITS-1:0]    tag_wdata,
    output logic [WAYS-1:0]             tag_wmask,
    output logic [$clog2(DATA_ROWS)-1:0] data_addr,
    output logic                        data_en,
    output logic                        data_wmode,
    output logic [DATA_BITS-1:0]        data_wdata,
    output logic [DATA_MASK_BITS-1:0]   data_wmask,
    output logic                        cache_hold,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned SET_AW = $clog2(SETS);
    localparam int unsigned ROW_AW = $clog2(DATA_ROWS);
    localparam int unsigned CNT_W  = max_w(SET_AW, ROW_AW);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned TAG_W  = WAYS * TAG_BITS;

    warmup_state_e state_q, state_d;

    logic [SET_AW-1:0]         tag_addr_q, tag_addr_d;
    logic                      tag_en_q, tag_en_d;
    logic [TAG_W-1:0]          tag_wdata_q, tag_wdata_d;
    logic [WAYS-1:0]           tag_wmask_q, tag_wmask_d;
    logic [ROW_AW-1:0]         data_addr_q, data_addr_d;
    logic                      data_en_q, data_en_d;
    logic [DATA_BITS-1:0]      data_wdata_q, data_wdata_d;
    logic [DATA_MASK_BITS-1:0] data_wmask_q, data_wmask_d;
    logic                      in_ready_q, in_ready_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      cache_hold_q, cache_hold_d;

    logic              accept_c;
    logic              cnt_load, cnt_inc, cnt_at_last_c;
    logic [CNT_W-1:0]  cnt_last, row_cnt;
    logic              hold_load, hold_inc, hold_at_last_c;
    logic [HOLD_W-1:0] hold_cnt;

    warmup_row_counter #(.W(CNT_W)) u_row_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cnt_load),
        .load_val  ('0),
        .inc       (cnt_inc),
        .last_val  (cnt_last),
        .count     (row_cnt),
        .at_last_c (cnt_at_last_c)
    );

    // HOLD spans the last write-strobe cycle plus HOLD_CYCLES settle cycles.
    warmup_row_counter #(.W(HOLD_W)) u_hold_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (hold_load),
        .load_val  ('0),
        .inc       (hold_inc),
        .last_val  (HOLD_W'(HOLD_CYCLES)),
        .count     (hold_cnt),
        .at_last_c (hold_at_last_c)
    );

    assign accept_c = in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_inc      = 1'b0;
        hold_load    = 1'b0;
        hold_inc     = 1'b0;
        cnt_last     = (state_q == ST_TAG) ? CNT_W'(SETS - 1) : CNT_W'(DATA_ROWS - 1);
        tag_en_d     = 1'b0;
        tag_addr_d   = tag_addr_q;
        tag_wdata_d  = tag_wdata_q;
        tag_wmask_d  = tag_wmask_q;
        data_en_d    = 1'b0;
        data_addr_d  = data_addr_q;
        data_wdata_d = data_wdata_q;
        data_wmask_d = data_wmask_q;

        case (state_q)
            ST_IDLE: begin
                if (bypass) begin
                    state_d = ST_DONE;
                end else if (start) begin
                    state_d  = ST_TAG;
                    cnt_load = 1'b1;
                end
            end
            ST_TAG: begin
                if (accept_c) begin
                    tag_en_d    = 1'b1;
                    tag_addr_d  = row_cnt[SET_AW-1:0];
                    tag_wdata_d = in_data[TAG_W-1:0];
                    tag_wmask_d = '1;
                    if (cnt_at_last_c) begin
                        cnt_load = 1'b1;
                        state_d  = ST_DATA;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (accept_c) begin
                    data_en_d    = 1'b1;
                    data_addr_d  = row_cnt[ROW_AW-1:0];
                    data_wdata_d = in_data;
                    data_wmask_d = '1;
                    if (cnt_at_last_c) begin
                        hold_load = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_at_last_c) begin
                    state_d = ST_DONE;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d   = (state_d == ST_TAG) || (state_d == ST_DATA);
        busy_d       = in_ready_d || (state_d == ST_HOLD);
        done_d       = (state_d == ST_DONE);
        cache_hold_d = !done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tag_addr_q   <= '0;
            tag_en_q     <= 1'b0;
            tag_wdata_q  <= '0;
            tag_wmask_q  <= '0;
            data_addr_q  <= '0;
            data_en_q    <= 1'b0;
            data_wdata_q <= '0;
            data_wmask_q <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cache_hold_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            tag_addr_q   <= tag_addr_d;
            tag_en_q     <= tag_en_d;
            tag_wdata_q  <= tag_wdata_d;
            tag_wmask_q  <= tag_wmask_d;
            data_addr_q  <= data_addr_d;
            data_en_q    <= data_en_d;
            data_wdata_q <= data_wdata_d;
            data_wmask_q <= data_wmask_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cache_hold_q <= cache_hold_d;
        end
    end

    assign tag_addr   = tag_addr_q;
    assign tag_en     = tag_en_q;
    assign tag_wmode  = tag_en_q;
    assign tag_wdata  = tag_wdata_q;
    assign tag_wmask  = tag_wmask_q;
    assign data_addr  = data_addr_q;
    assign data_en    = data_en_q;
    assign data_wmode = data_en_q;
    assign data_wdata = data_wdata_q;
    assign data_wmask = data_wmask_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cache_hold = cache_hold_q;

endmodule

// File: tb/tb_dcache_warmup_sequencer.sv
// Randomized scoreboard bench for dcache_warmup_sequencer: a driver predicts each
// SRAM write from the image-row order and a negedge monitor retires them.
module tb_dcache_warmup_sequencer;

    localparam int SETS = 64;
    localparam int DATA_ROWS = 512;
    localparam int HOLD = 10;
    localparam int BEATS = SETS + DATA_ROWS;

    logic clk = 1'b0;
    logic rst_n, start, bypass, in_valid, in_ready;
    logic [255:0] in_data;
    logic [5:0]   tag_addr;
    logic         tag_en, tag_wmode;
    logic [87:0]  tag_wdata;
    logic [3:0]   tag_wmask;
    logic [8:0]   data_addr;
    logic         data_en, data_wmode;
    logic [255:0] data_wdata;
    logic [31:0]  data_wmask;
    logic         cache_hold, busy, done;

    logic         start2, bypass2, in_valid2, in_ready2;
    logic [1:0]   tag_addr2;
    logic         tag_en2, tag_wmode2;
    logic [87:0]  tag_wdata2;
    logic [3:0]   tag_wmask2;
    logic [2:0]   data_addr2;
    logic         data_en2, data_wmode2;
    logic [255:0] data_wdata2;
    logic [31:0]  data_wmask2;
    logic         cache_hold2, busy2, done2;

    always #5 clk = ~clk;

    dcache_warmup_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bypass(bypass),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tag_addr(tag_addr), .tag_en(tag_en), .tag_wmode(tag_wmode),
        .tag_wdata(tag_wdata), .tag_wmask(tag_wmask),
        .data_addr(data_addr), .data_en(data_en), .data_wmode(data_wmode),
        .data_wdata(data_wdata), .data_wmask(data_wmask),
        .cache_hold(cache_hold), .busy(busy), .done(done)
    );

    dcache_warmup_sequencer #(.SETS(4), .DATA_ROWS(8), .HOLD_CYCLES(1)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start2), .bypass(bypass2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
        .tag_addr(tag_addr2), .tag_en(tag_en2), .tag_wmode(tag_wmode2),
        .tag_wdata(tag_wdata2), .tag_wmask(tag_wmask2),
        .data_addr(data_addr2), .data_en(data_en2), .data_wmode(data_wmode2),
        .data_wdata(data_wdata2), .data_wmask(data_wmask2),
        .cache_hold(cache_hold2), .busy(busy2), .done(done2)
    );

    typedef struct {
        bit           is_tag;
        int           addr;
        logic [255:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  last_edge = 0;
    int  sm_tag_cnt = 0;
    int  sm_data_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Image row k: first SETS beats are tag rows, the rest are data rows in order.
    function automatic wr_t predict(input int k, input logic [255:0] d);
        wr_t e;
        e.is_tag = (k < SETS);
        e.addr   = (k < SETS) ? k : k - SETS;
        e.data   = (k < SETS) ? {168'd0, d[87:0]} : d;
        return e;
    endfunction

    function automatic logic [255:0] mk(input int k, input bit pat);
        logic [255:0] r;
        logic [5:0]   s;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (pat && k < SETS) begin
            s = 6'(k);
            r[87:0] = {4{s, 16'hA5A5}};
        end
        return r;
    endfunction

    // Scoreboard retirement and idle-handshake checks.
    always @(negedge clk) begin
        if (tag_en || data_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_write: got tag_en=%0b data_en=%0b expected no write", tag_en, data_en);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_is_tag", tag_en, mon_e.is_tag);
                check("wr_is_data", data_en, !mon_e.is_tag);
                if (mon_e.is_tag) begin
                    check("tag_addr", tag_addr, mon_e.addr);
                    check("tag_wdata", tag_wdata, mon_e.data);
                    check("tag_wmask", tag_wmask, 4'hF);
                    check("tag_wmode", tag_wmode, 1'b1);
                end else begin
                    check("data_addr", data_addr, mon_e.addr);
                    check("data_wdata", data_wdata, mon_e.data);
                    check("data_wmask", data_wmask, 32'hFFFF_FFFF);
                    check("data_wmode", data_wmode, 1'b1);
                end
            end
        end else begin
            check("wmode_idle", {tag_wmode, data_wmode}, 2'b00);
        end
        if (!busy) check("in_ready_not_busy", in_ready, 1'b0);
    end

    always @(negedge clk) begin
        if (tag_en2) sm_tag_cnt++;
        if (data_en2) sm_data_cnt++;
    end

    task automatic check_reset_vals();
        check("rst_tag_en", {tag_en, tag_wmode}, 2'b00);
        check("rst_tag_addr", tag_addr, 6'd0);
        check("rst_tag_wdata", tag_wdata, 88'd0);
        check("rst_tag_wmask", tag_wmask, 4'd0);
        check("rst_data_en", {data_en, data_wmode}, 2'b00);
        check("rst_data_addr", data_addr, 9'd0);
        check("rst_data_wdata", data_wdata, 256'd0);
        check("rst_data_wmask", data_wmask, 32'd0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cache_hold", cache_hold, 1'b1);
    endtask

    // Called #1 after a posedge with the DUT in IDLE.
    task automatic run_load(input int duty, input bit pat, input int stop_at, input int pulse_at);
        int k, budget, n, start_edge;
        bit acc;
        k = 0;
        budget = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_edge = cyc;
        while (k < stop_at && budget < 20000) begin
            in_valid = ($urandom_range(99) < 32'(duty));
            in_data  = mk(k, pat);
            start    = (k == pulse_at);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(predict(k, in_data));
            @(posedge clk); #1;
            if (acc) begin
                k++;
                last_edge = cyc;
            end
            budget++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("load_within_budget", budget < 20000, 1'b1);
        if (stop_at < BEATS) return;
        n = 0;
        @(negedge clk);
        while (!done && n < 64) begin
            check("in_ready_hold", in_ready, 1'b0);
            check("cache_hold_hold", cache_hold, 1'b1);
            n++;
            @(negedge clk);
        end
        check("done_after_last_beat", cyc - last_edge, HOLD + 1);
        if (duty >= 100) check("done_total_latency", cyc - start_edge, 1 + SETS + DATA_ROWS + HOLD);
        check("cache_hold_done", cache_hold, 1'b0);
        check("busy_done", busy, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic run_small();
        int acc_n, n, last2;
        bit a;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        in_valid2 = 1'b1;
        acc_n = 0;
        n = 0;
        last2 = 0;
        while (acc_n < 12 && n < 100) begin
            @(negedge clk);
            a = in_ready2;
            @(posedge clk); #1;
            if (a) begin
                acc_n++;
                last2 = cyc;
            end
            n++;
        end
        in_valid2 = 1'b0;
        while (!done2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("small_done_latency", cyc - last2, 2);
        check("small_tag_writes", sm_tag_cnt, 4);
        check("small_data_writes", sm_data_cnt, 8);
        check("small_cache_hold", cache_hold2, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bypass = 1'b0; in_valid = 1'b0; in_data = '0;
        start2 = 1'b0; bypass2 = 1'b0; in_valid2 = 1'b0;
        #12;
        check_reset_vals();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Continuous patterned load with a stray start during DATA.
        run_load(100, 1'b1, BEATS, SETS + 100);
        @(posedge clk); #1;
        start = 1'b1; bypass = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; bypass = 1'b0;
        repeat (4) @(negedge clk);
        check("done_sticky", done, 1'b1);
        check("done_no_restart", busy, 1'b0);

        // Reset partway through the tag rows.
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_load(100, 1'b0, 30, -1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Fresh load from row 0 with ~50% valid duty.
        run_load(50, 1'b0, BEATS, -1);

        // Bypass wins over start in IDLE.
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("bypass_pre_done", done, 1'b0);
        @(posedge clk); #1;
        bypass = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        bypass = 1'b0; start = 1'b0;
        @(negedge clk);
        check("bypass_done", done, 1'b1);
        check("bypass_cache_hold", cache_hold, 1'b0);
        check("bypass_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("bypass_done_stays", done, 1'b1);
        @(posedge clk); #1;

        run_small();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_warmup_sequencer.md
# dcache_warmup_sequencer

Sequences functional-warmup state into the L1 DCache tag and data SRAMs through their normal RW0 write ports, replacing per-set `force`/`release` injection. It accepts a stream of pre-formatted rows: one tag row per set (all ways packed), then one data row per data-array address. It writes each row into the correct array and holds the DCache in reset until the image is fully written plus a settle window. It sits between the warmup image source (testbench reader or DMA) and the DCache SRAM macros.

## Interface
Parameters:
- SETS, 64, cache sets; tag-array depth
- WAYS, 4, ways packed per tag row
- TAG_BITS, 22, per-way tag width including 2 coherency bits
- DATA_ROWS, 512, data-array depth
- DATA_BITS, 256, data-array row width; also the input beat width
- DATA_MASK_BITS, 32, data-array write-mask width
- HOLD_CYCLES, 10, cycles `cache_hold` stays high after the last write; must be ≥1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin load; sampled only in IDLE
- bypass  in  1  skip load (cold cache); sampled only in IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when high with in_valid
- in_data  in  DATA_BITS  tag row in low WAYS*TAG_BITS bits, or full data row
- tag_addr  out  $clog2(SETS)  tag RW0 address
- tag_en  out  1  tag RW0 enable
- tag_wmode  out  1  tag RW0 write mode
- tag_wdata  out  WAYS*TAG_BITS  tag RW0 write data
- tag_wmask  out  WAYS  tag RW0 per-way mask
- data_addr  out  $clog2(DATA_ROWS)  data RW0 address
- data_en  out  1  data RW0 enable
- data_wmode  out  1  data RW0 write mode
- data_wdata  out  DATA_BITS  data RW0 write data
- data_wmask  out  DATA_MASK_BITS  data RW0 mask
- cache_hold  out  1  keep DCache in reset
- busy  out  1  load in progress (TAG, DATA or HOLD)
- done  out  1  sequence complete; sticky until reset

## Operation
- FSM states: IDLE, TAG, DATA, HOLD, DONE.
- IDLE: in_ready=0. `bypass`=1 → DONE, which takes priority over `start`. Otherwise `start`=1 → TAG, with the row counter at 0.
- TAG: in_ready=1. Each accepted beat writes tag row `counter`:
  - tag_wdata = in_data[WAYS*TAG_BITS-1:0], tag_wmask all ones.
  - On the beat where counter reaches SETS-1: counter → 0, state → DATA.
- DATA: in_ready=1. Each accepted beat writes data row `counter` with data_wmask all ones. The beat at DATA_ROWS-1 → HOLD.
- HOLD: in_ready=0. Timer counts HOLD_CYCLES cycles, then → DONE.
- DONE: terminal. in_ready=0, done=1, cache_hold=0. `start` and `bypass` are ignored.
- `start` or `bypass` outside IDLE is ignored. In_valid outside TAG/DATA is never accepted.
- en/wmode/addr/wdata/wmask are registered. en=wmode=1 for exactly one cycle per accepted beat; otherwise en=wmode=0 and addr/wdata/wmask hold their last value.
- Reset values: state IDLE, counter 0, all en/wmode 0, addr/wdata/wmask 0, in_ready 0, busy 0, done 0, cache_hold 1.
- Reset mid-load: returns to IDLE with cache_hold=1. The partially written arrays are not cleared; the next `start` reloads all rows.

## Timing
- Beat accepted on edge N → SRAM write strobe (en=wmode=1, addr, wdata) during cycle N+1.
- Back-to-back beats give one write per cycle; gaps in in_valid give gaps in en.
- The TAG→DATA switch costs no bubble: the beat after the last tag beat is accepted the next cycle.
- Last data beat accepted at N → HOLD entered at N+1. done=1 and cache_hold=0 from N+1+HOLD_CYCLES.
- `bypass` in IDLE at edge N → done=1 and cache_hold=0 from N+1.
- Total with continuous input: start at N → done at N+1+SETS+DATA_ROWS+HOLD_CYCLES.

## Structure
- Package `dcache_warmup_pkg`: state enum `warmup_state_e`, and constants SET_W=$clog2(SETS) and ROW_W=$clog2(DATA_ROWS) as functions of the parameter defaults.
- One sub-module, `warmup_row_counter`: a loadable up-counter with a terminal-count flag. It is instanced twice, once as the row counter (width ROW_W) and once as the hold timer.

## Test plan
- Continuous load with defaults, tag row s = {4{s[5:0],16'hA5A5}}:
  - tag_addr steps 0..63 on consecutive cycles with the matching wdata and tag_wmask=4'hF.
  - data_addr steps 0..511.
  - done rises exactly 1+64+512+10 cycles after start.
- Random in_valid gaps (~50% duty):
  - every row is written exactly once, in order, with no write on a gap cycle.
  - in_ready=0 in IDLE, HOLD and DONE.
- bypass=1 with start=1 in IDLE → done=1 and cache_hold=0 one cycle later; no en pulse on either array.
- start pulsed during DATA and again in DONE → no counter restart; done timing unchanged.
- rst_n asserted asynchronously at tag row 30:
  - all outputs immediately take their reset values; cache_hold=1.
  - a fresh start rewrites rows from 0.
- HOLD_CYCLES=1 → done rises 2 cycles after the last data beat is accepted.
